// File: rtl/out_uart_tx.sv
// Byte FIFO plus 8N1 UART transmitter behind the core's single-cycle character strobe.
// Bytes arriving while the FIFO is full are dropped and latched into a sticky overflow flag.
module out_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          out_en,
  input  logic [7:0]                    out_data,
  output logic                          tx,
  output logic                          busy,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [AW:0]   wptr, rptr;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [7:0]    shift;
  logic [2:0]    bit_idx;
  logic [CW-1:0] baud;
  logic          full, not_empty, baud_end, push, pop;

  // Pointers carry one extra wrap bit, so the difference is the exact occupancy.
  assign fifo_level = wptr - rptr;
  assign full       = (fifo_level == (AW+1)'(FIFO_DEPTH));
  assign not_empty  = (fifo_level != '0);
  assign baud_end   = (baud == CW'(CLKS_PER_BIT - 1));
  assign push       = out_en && !full;
  assign pop        = not_empty && ((state == IDLE) || (state == STOP && baud_end));
  assign busy       = (state != IDLE) || not_empty;

  always_ff @(posedge clock) begin
    if (push) mem[wptr[AW-1:0]] <= out_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr     <= '0;
      rptr     <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (out_en && full) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      tx      <= 1'b1;
      shift   <= '0;
      bit_idx <= '0;
      baud    <= '0;
    end else begin
      case (state)
        IDLE: begin
          tx   <= 1'b1;
          baud <= '0;
          if (pop) begin
            shift <= mem[rptr[AW-1:0]];
            state <= START;
            tx    <= 1'b0;
          end
        end
        START: begin
          if (baud_end) begin
            baud    <= '0;
            bit_idx <= '0;
            state   <= DATA;
            tx      <= shift[0];
          end else begin
            baud <= baud + 1'b1;
          end
        end
        DATA: begin
          if (baud_end) begin
            baud  <= '0;
            shift <= shift >> 1;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shift[1];
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        STOP: begin
          if (baud_end) begin
            baud <= '0;
            // Chain straight into the next start bit so bursts leave no idle gap.
            if (pop) begin
              shift <= mem[rptr[AW-1:0]];
              state <= START;
              tx    <= 1'b0;
            end else begin
              state <= IDLE;
              tx    <= 1'b1;
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_out_uart_tx.sv
// Directed bench for out_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// Frames are decoded by mid-bit sampling; timings are counted in clock edges from the strobe.
module tb_out_uart_tx;
  localparam int C = 4;
  localparam int D = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic       out_en;
  logic [7:0] out_data;
  logic       tx, busy, overflow;
  logic [2:0] fifo_level;

  int checks = 0;
  int fails  = 0;

  out_uart_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
    .clock(clock), .reset(reset), .out_en(out_en), .out_data(out_data),
    .tx(tx), .busy(busy), .overflow(overflow), .fifo_level(fifo_level)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Samples the rest of one frame starting k cycles into its start bit; ends on cycle 0 of the next bit slot.
  task automatic rx_frame(input int k, output logic [9:0] bits);
    bits = '0;
    for (int t = k; t < 10*C; t++) begin
      if (t % C == C/2) bits[t/C] = tx;
      tick();
    end
  endtask

  task automatic wait_start(input int limit, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < limit; n++) begin
      if (tx === 1'b0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic pulse_reset();
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    tick();
  endtask

  task automatic test_reset_initial();
    reset = 1'b1; out_en = 1'b0; out_data = 8'h00;
    #3;
    checks++; if (tx !== 1'b1) begin fails++; $display("FAIL reset_init_tx got=%b want=1", tx); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_init_busy got=%b want=0", busy); end
    checks++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_init_ovf got=%b want=0", overflow); end
    checks++; if (fifo_level !== 3'd0) begin fails++; $display("FAIL reset_init_level got=%0d want=0", fifo_level); end
    #4 reset = 1'b0;
    tick();
  endtask

  task automatic test_single();
    logic [9:0] exp;
    exp = {1'b1, 8'h41, 1'b0};
    out_en = 1'b1; out_data = 8'h41;
    tick();
    out_en = 1'b0;
    checks++; if (fifo_level !== 3'd1) begin fails++; $display("FAIL single_level_E got=%0d want=1", fifo_level); end
    checks++; if (busy !== 1'b1) begin fails++; $display("FAIL single_busy_E got=%b want=1", busy); end
    checks++; if (tx !== 1'b1) begin fails++; $display("FAIL single_tx_E got=%b want=1", tx); end
    tick();
    checks++; if (fifo_level !== 3'd0) begin fails++; $display("FAIL single_level_E1 got=%0d want=0", fifo_level); end
    for (int i = 0; i < 10*C; i++) begin
      checks++;
      if (tx !== exp[i/C]) begin fails++; $display("FAIL single_tx_cycle%0d got=%b want=%b", i, tx, exp[i/C]); end
      if (i == 10*C-1) begin
        checks++; if (busy !== 1'b1) begin fails++; $display("FAIL single_busy_last got=%b want=1", busy); end
      end
      tick();
    end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL single_busy_end got=%b want=0", busy); end
    checks++; if (tx !== 1'b1) begin fails++; $display("FAIL single_tx_idle got=%b want=1", tx); end
  endtask

  task automatic test_burst();
    logic [7:0] bytes [3];
    logic [9:0] f;
    bytes[0] = 8'h48; bytes[1] = 8'h69; bytes[2] = 8'h0A;
    for (int i = 0; i < 3; i++) begin
      out_en = 1'b1; out_data = bytes[i];
      tick();
    end
    out_en = 1'b0;
    checks++; if (tx !== 1'b0) begin fails++; $display("FAIL burst_start got=%b want=0", tx); end
    for (int i = 0; i < 3; i++) begin
      rx_frame((i == 0) ? 1 : 0, f);
      checks++;
      if (f !== {1'b1, bytes[i], 1'b0}) begin
        fails++; $display("FAIL burst_frame%0d got=%h want=%h", i, f, {1'b1, bytes[i], 1'b0});
      end
      if (i < 2) begin
        checks++; if (tx !== 1'b0) begin fails++; $display("FAIL burst_gap%0d got=%b want=0", i, tx); end
      end
    end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL burst_busy_end got=%b want=0", busy); end
    checks++; if (overflow !== 1'b0) begin fails++; $display("FAIL burst_ovf got=%b want=0", overflow); end
  endtask

  task automatic test_overflow();
    logic [2:0] lvl [7];
    logic       ovf [7];
    logic [9:0] f;
    lvl = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4};
    ovf = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 7; i++) begin
      out_en = 1'b1; out_data = 8'(i);
      tick();
      checks++; if (fifo_level !== lvl[i]) begin fails++; $display("FAIL ovf_level%0d got=%0d want=%0d", i, fifo_level, lvl[i]); end
      checks++; if (overflow !== ovf[i]) begin fails++; $display("FAIL ovf_flag%0d got=%b want=%b", i, overflow, ovf[i]); end
    end
    out_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rx_frame((i == 0) ? 5 : 0, f);
      checks++;
      if (f[9:1] !== {1'b1, 8'(i)}) begin fails++; $display("FAIL ovf_byte%0d got=%h want=%h", i, f[9:1], {1'b1, 8'(i)}); end
    end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL ovf_busy_end got=%b want=0", busy); end
    checks++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_sticky got=%b want=1", overflow); end
  endtask

  task automatic test_reset_midrun();
    out_en = 1'b1; out_data = 8'hC3;
    tick();
    out_data = 8'h3C;
    tick();
    out_en = 1'b0;
    repeat (6) tick();
    checks++; if (busy !== 1'b1) begin fails++; $display("FAIL mid_busy_pre got=%b want=1", busy); end
    #3 reset = 1'b1;
    #1;
    checks++; if (tx !== 1'b1) begin fails++; $display("FAIL mid_tx got=%b want=1", tx); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL mid_busy got=%b want=0", busy); end
    checks++; if (overflow !== 1'b0) begin fails++; $display("FAIL mid_ovf got=%b want=0", overflow); end
    checks++; if (fifo_level !== 3'd0) begin fails++; $display("FAIL mid_level got=%0d want=0", fifo_level); end
    #2 reset = 1'b0;
    repeat (3) tick();
    checks++; if (tx !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL mid_after tx=%b busy=%b want tx=1 busy=0", tx, busy);
    end
  endtask

  task automatic test_full_pushpop();
    logic [9:0] f;
    for (int i = 0; i < 5; i++) begin
      out_en = 1'b1; out_data = 8'hA0 + 8'(i);
      tick();
    end
    out_en = 1'b0;
    // First strobe edge E; start bit began after E+1, so the stop bit ends on edge E+1+10*C.
    repeat (10*C - 4) tick();
    checks++; if (fifo_level !== 3'd4) begin fails++; $display("FAIL fpp_level_pre got=%0d want=4", fifo_level); end
    checks++; if (overflow !== 1'b0) begin fails++; $display("FAIL fpp_ovf_pre got=%b want=0", overflow); end
    out_en = 1'b1; out_data = 8'h55;
    tick();
    out_en = 1'b0;
    checks++; if (fifo_level !== 3'd3) begin fails++; $display("FAIL fpp_level_post got=%0d want=3", fifo_level); end
    checks++; if (overflow !== 1'b1) begin fails++; $display("FAIL fpp_ovf_post got=%b want=1", overflow); end
    checks++; if (tx !== 1'b0) begin fails++; $display("FAIL fpp_next_start got=%b want=0", tx); end
    for (int i = 1; i < 5; i++) begin
      rx_frame(0, f);
      checks++;
      if (f !== {1'b1, 8'hA0 + 8'(i), 1'b0}) begin
        fails++; $display("FAIL fpp_frame%0d got=%h want=%h", i, f, {1'b1, 8'hA0 + 8'(i), 1'b0});
      end
    end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL fpp_busy_end got=%b want=0", busy); end
  endtask

  task automatic test_wrap();
    bit ok;
    bit over_one = 1'b0;
    logic [9:0] f;
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          out_en = 1'b1; out_data = 8'(i*37 + 5);
          tick();
          out_en = 1'b0;
          repeat (10*C - 1) tick();
        end
      end
      begin
        wait_start(20, ok);
        checks++; if (!ok) begin fails++; $display("FAIL wrap_start_timeout got=no_start want=start"); end
        if (ok) begin
          for (int i = 0; i < 20; i++) begin
            rx_frame(0, f);
            checks++;
            if (f !== {1'b1, 8'(i*37 + 5), 1'b0}) begin
              fails++; $display("FAIL wrap_frame%0d got=%h want=%h", i, f, {1'b1, 8'(i*37 + 5), 1'b0});
            end
          end
        end
      end
      begin
        for (int t = 0; t < 20*10*C + 10; t++) begin
          if (fifo_level > 3'd1) over_one = 1'b1;
          tick();
        end
      end
    join
    checks++; if (over_one) begin fails++; $display("FAIL wrap_level_max got=>1 want<=1"); end
    checks++; if (overflow !== 1'b0) begin fails++; $display("FAIL wrap_ovf got=%b want=0", overflow); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL wrap_busy_end got=%b want=0", busy); end
  endtask

  initial begin
    test_reset_initial();
    test_single();
    repeat (3) tick();
    test_burst();
    repeat (3) tick();
    test_overflow();
    test_reset_midrun();
    test_full_pushpop();
    pulse_reset();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
